// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM state encoding and op-class helpers for the multi-cycle ALU
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_DIVU = 4'd9;
  localparam logic [3:0] OP_REMU = 4'd10;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || is_div_op(op);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// rtl/alu_iter_muldiv.sv - shared one-bit-per-cycle shift-add multiplier / restoring divider
module alu_iter_muldiv #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             done,
  output logic [WIDTH-1:0] o_res_lo,
  output logic [WIDTH-1:0] o_res_hi
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH - 1);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_m;
  logic [SHW:0]     r_cnt;
  logic             r_busy;
  logic             r_div;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_acc_nx;
  logic [WIDTH-1:0] w_sh_nx;

  // MUL: {acc, sh} is the product register, multiplier consumed from sh[0].
  assign w_sum = {1'b0, r_acc} + (r_sh[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});

  // DIV: remainder in acc, dividend shifts out of sh while quotient bits shift in.
  assign w_shift = {r_acc, r_sh[WIDTH-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_m};
  assign w_ge    = ~w_diff[WIDTH+1];

  always_comb begin
    w_acc_nx = w_sum[WIDTH:1];
    w_sh_nx  = {w_sum[0], r_sh[WIDTH-1:1]};
    if (r_div) begin
      w_acc_nx = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      w_sh_nx  = {r_sh[WIDTH-2:0], w_ge};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_sh   <= '0;
      r_m    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_div  <= 1'b0;
    end else if (start) begin
      r_acc  <= '0;
      r_sh   <= i_a;
      r_m    <= i_b;
      r_cnt  <= CNT_INIT;
      r_busy <= 1'b1;
      r_div  <= op_is_div;
    end else if (r_busy) begin
      r_acc <= w_acc_nx;
      r_sh  <= w_sh_nx;
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Results are the post-step values so the caller can capture on the final step edge.
  assign done     = r_busy && (r_cnt == '0);
  assign o_res_lo = w_sh_nx;
  assign o_res_hi = w_acc_nx;

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multi-cycle ALU: handshake FSM, single-cycle ops, registered outputs
module alu_multicycle
  import alu_pkg::*;
#(
  parameter  int WIDTH = 24,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             a_invert,
  input  logic             b_invert,
  input  logic [3:0]       op,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             cout,
  output logic             div_by_zero
);

  state_t r_state;
  state_t w_state_nx;

  logic             w_accept;
  logic             w_start;
  logic             w_done;
  logic [WIDTH-1:0] w_iter_lo;
  logic [WIDTH-1:0] w_iter_hi;

  logic [WIDTH-1:0] w_a_eff;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic [SHW-1:0]   w_shamt_sat;
  logic [WIDTH-1:0] w_sc_result;
  logic             w_sc_ovf;
  logic             w_sc_cout;

  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic             r_zero;
  logic             r_overflow;
  logic             r_cout;
  logic             r_dbz;
  logic [3:0]       r_op;
  logic             r_dbz_pend;

  assign w_accept = in_valid && in_ready;
  assign w_start  = w_accept && is_iter_op(op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nx = is_iter_op(op) ? ST_BUSY : ST_DONE;
        end
      end
      ST_BUSY: begin
        if (w_done) begin
          w_state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
  end

  alu_iter_muldiv #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_start),
    .op_is_div(is_div_op(op)),
    .i_a      (a),
    .i_b      (b),
    .done     (w_done),
    .o_res_lo (w_iter_lo),
    .o_res_hi (w_iter_hi)
  );

  assign w_a_eff = a_invert ? ~a : a;
  assign w_b_eff = b_invert ? ~b : b;
  assign w_add   = {1'b0, w_a_eff} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, b_invert};
  assign w_sub   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  assign w_add_ovf = (w_a_eff[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                     (w_add[WIDTH-1] != w_a_eff[WIDTH-1]);
  assign w_sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);

  // Out-of-range shift amounts saturate at WIDTH-1 rather than wrapping.
  assign w_shamt_sat = ({1'b0, shamt} >= (SHW+1)'(WIDTH)) ? SHW'(WIDTH - 1) : shamt;

  always_comb begin
    w_sc_result = '0;
    w_sc_ovf    = 1'b0;
    w_sc_cout   = 1'b0;
    case (op)
      OP_AND: w_sc_result = w_a_eff & w_b_eff;
      OP_OR:  w_sc_result = w_a_eff | w_b_eff;
      OP_XOR: w_sc_result = w_a_eff ^ w_b_eff;
      OP_ADD: begin
        w_sc_result = w_add[WIDTH-1:0];
        w_sc_ovf    = w_add_ovf;
        w_sc_cout   = w_add[WIDTH];
      end
      OP_SLT: begin
        w_sc_result = {{(WIDTH-1){1'b0}}, w_sub[WIDTH-1] ^ w_sub_ovf};
        w_sc_ovf    = w_sub_ovf;
      end
      OP_SLL: w_sc_result = a << w_shamt_sat;
      OP_SRL: w_sc_result = a >> w_shamt_sat;
      OP_SRA: w_sc_result = $unsigned($signed(a) >>> w_shamt_sat);
      default: w_sc_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
      r_cout      <= 1'b0;
      r_dbz       <= 1'b0;
      r_op        <= '0;
      r_dbz_pend  <= 1'b0;
    end else if (w_accept && !is_iter_op(op)) begin
      r_result    <= w_sc_result;
      r_result_hi <= '0;
      r_zero      <= (w_sc_result == '0);
      r_overflow  <= w_sc_ovf;
      r_cout      <= w_sc_cout;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      r_op       <= op;
      r_dbz_pend <= (b == '0);
    end else if (w_done) begin
      r_overflow <= 1'b0;
      r_cout     <= 1'b0;
      if (r_op == OP_MUL) begin
        r_result    <= w_iter_lo;
        r_result_hi <= w_iter_hi;
        r_zero      <= ({w_iter_hi, w_iter_lo} == '0);
        r_dbz       <= 1'b0;
      end else if (r_op == OP_DIVU) begin
        r_result    <= w_iter_lo;
        r_result_hi <= '0;
        r_zero      <= (w_iter_lo == '0);
        r_dbz       <= r_dbz_pend;
      end else begin
        r_result    <= w_iter_hi;
        r_result_hi <= '0;
        r_zero      <= (w_iter_hi == '0);
        r_dbz       <= r_dbz_pend;
      end
    end
  end

  assign result      = r_result;
  assign result_hi   = r_result_hi;
  assign zero        = r_zero;
  assign overflow    = r_overflow;
  assign cout        = r_cout;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - directed self-checking bench for alu_multicycle (WIDTH=24)
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int W   = 24;
  localparam int SHW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          a_invert;
  logic          b_invert;
  logic [3:0]    op;
  logic [SHW-1:0] shamt;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic [W-1:0]  result_hi;
  logic          zero;
  logic          overflow;
  logic          cout;
  logic          div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .a_invert   (a_invert),
    .b_invert   (b_invert),
    .op         (op),
    .shamt      (shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .result_hi  (result_hi),
    .zero       (zero),
    .overflow   (overflow),
    .cout       (cout),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept_op(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic ai, input logic bi, input logic [SHW-1:0] sh);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = va; b = vb; a_invert = ai; b_invert = bi; shamt = sh;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic ai, input logic bi, input logic [SHW-1:0] sh,
                       output int latency);
    accept_op(o, va, vb, ai, bi, sh);
    latency = 1;
    while (!out_valid && latency < 60) begin
      @(posedge clk);
      latency++;
      @(negedge clk);
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; a_invert = 1'b0; b_invert = 1'b0; op = '0; shamt = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'({result_hi, result, zero, overflow, cout, div_by_zero}), 64'd0);
    rst_n = 1'b1;

    issue(OP_ADD, 24'd0, 24'd10, 1'b0, 1'b0, '0, lat);
    check("add_lat", 64'(lat), 64'd1);
    check("add_res", 64'(result), 64'd10);
    check("add_cout", 64'(cout), 64'd0);
    retire();

    issue(OP_ADD, 24'd5, 24'd2, 1'b0, 1'b1, '0, lat);
    check("sub_res", 64'(result), 64'd3);
    check("sub_cout", 64'(cout), 64'd1);
    retire();

    issue(OP_MUL, 24'd8, 24'd3, 1'b0, 1'b0, '0, lat);
    check("mul_lat", 64'(lat), 64'd25);
    check("mul_res", 64'(result), 64'd24);
    check("mul_hi", 64'(result_hi), 64'd0);
    retire();

    issue(OP_MUL, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0, '0, lat);
    check("mul_max", 64'({result_hi, result}), 64'hFFFFFE000001);
    retire();

    issue(OP_MUL, 24'h001000, 24'h001000, 1'b0, 1'b0, '0, lat);
    check("mul_carry_prod", 64'({result_hi, result}), 64'h000001000000);
    check("mul_carry_zero", 64'(zero), 64'd0);
    retire();

    issue(OP_DIVU, 24'd100, 24'd7, 1'b0, 1'b0, '0, lat);
    check("divu_lat", 64'(lat), 64'd25);
    check("divu_res", 64'(result), 64'd14);
    retire();

    issue(OP_REMU, 24'd100, 24'd7, 1'b0, 1'b0, '0, lat);
    check("remu_res", 64'(result), 64'd2);
    retire();

    issue(OP_DIVU, 24'd5, 24'd0, 1'b0, 1'b0, '0, lat);
    check("div0_lat", 64'(lat), 64'd25);
    check("div0_res", 64'(result), 64'hFFFFFF);
    check("div0_flag", 64'(div_by_zero), 64'd1);
    retire();

    issue(OP_REMU, 24'd5, 24'd0, 1'b0, 1'b0, '0, lat);
    check("rem0_res", 64'(result), 64'd5);
    retire();

    issue(OP_SLT, 24'd2, 24'd5, 1'b0, 1'b0, '0, lat);
    check("slt_small", 64'(result), 64'd1);
    retire();

    issue(OP_SLT, 24'h800000, 24'd1, 1'b0, 1'b0, '0, lat);
    check("slt_neg_res", 64'(result), 64'd1);
    check("slt_neg_ovf", 64'(overflow), 64'd1);
    retire();

    issue(OP_ADD, 24'h7FFFFF, 24'd1, 1'b0, 1'b0, '0, lat);
    check("add_ovf_res", 64'(result), 64'h800000);
    check("add_ovf_flag", 64'(overflow), 64'd1);
    retire();

    issue(OP_SRA, 24'h800000, 24'd0, 1'b0, 1'b0, 5'd4, lat);
    check("sra_res", 64'(result), 64'hF80000);
    retire();

    issue(OP_SRL, 24'h800000, 24'd0, 1'b0, 1'b0, 5'd30, lat);
    check("srl_sat", 64'(result), 64'd1);
    retire();

    issue(OP_AND, 24'hF0F0F0, 24'hFFFF00, 1'b1, 1'b0, '0, lat);
    check("and_ainv", 64'(result), 64'h0F0F00);
    retire();

    issue(4'd12, 24'd7, 24'd9, 1'b0, 1'b0, '0, lat);
    check("badop_res", 64'(result), 64'd0);
    check("badop_zero", 64'(zero), 64'd1);
    retire();

    issue(OP_ADD, 24'd3, 24'd4, 1'b0, 1'b0, '0, lat);
    in_valid = 1'b1; op = OP_MUL; a = 24'd9; b = 24'd9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_result", 64'(result), 64'd7);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    retire();
    check("bp_after_valid", 64'(out_valid), 64'd0);
    check("bp_after_ready", 64'(in_ready), 64'd1);

    accept_op(OP_MUL, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0, '0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_outputs", 64'({result_hi, result, zero, overflow, cout, div_by_zero}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(OP_ADD, 24'd1, 24'd1, 1'b0, 1'b0, '0, lat);
    check("post_abort_lat", 64'(lat), 64'd1);
    check("post_abort_res", 64'(result), 64'd2);
    retire();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
